pwm_sample_sched: RTL and testbench
===================================

# pwm_sample_sched

Sample-rate scheduler that feeds the 8-bit PWM audio output stage of the effects pedal. It buffers duty samples written by the bus/CPU side in a small FIFO and generates the sample-period tick. On each tick it hands the next duty value to the PWM datapath with a one-cycle load strobe. It also reports fill level, under/overflow and a low-water interrupt so software can keep the stream fed.

## Interface
- PERIOD, 12000: clocks per sample (12000 → 4 kHz at 48 MHz); legal 2..2^24-1
- DEPTH, 16: FIFO entries, power of two
- PRIME_LVL, 8: entries required before playback starts, 1..DEPTH
- LOW_WATER, 4: irq threshold
- IDLE_DUTY, 8'h80: duty driven when not playing (mid-scale silence)

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  sample write strobe
- wr_data  in  8  sample value
- ctrl_start  in  1  one-cycle start pulse
- ctrl_stop  in  1  one-cycle stop pulse
- clr_flags  in  1  clears underrun/overflow sticky flags
- duty  out  8  duty value to PWM datapath
- duty_load  out  1  one-cycle strobe: duty has just changed
- pwm_en  out  1  PWM stage enable (high in RUN)
- level  out  log2(DEPTH)+1  FIFO occupancy
- wr_full  out  1  level == DEPTH
- running  out  1  state != IDLE
- underrun  out  1  sticky: tick with empty FIFO in RUN
- overflow  out  1  sticky: write while full
- irq  out  1  running && level <= LOW_WATER

## Operation
- States: IDLE, PRIME, RUN, STOPPING.
- IDLE: tick counter held at 0; FIFO accepts writes. ctrl_start → PRIME.
- PRIME: counter held at 0. When level ≥ PRIME_LVL → RUN; counter starts at 0 the next cycle.
- RUN: counter counts 0..PERIOD-1 and wraps. The tick is the cycle with counter == PERIOD-1.
  - Tick with FIFO non-empty: pop one entry, duty ← entry, duty_load pulses.
  - Tick with FIFO empty: underrun ← 1, duty holds, no duty_load.
- ctrl_stop in PRIME → IDLE immediately. ctrl_stop in RUN → STOPPING.
- STOPPING: counter keeps running. At the next tick: no pop, duty ← IDLE_DUTY, duty_load pulses, FIFO flushed (level → 0), → IDLE.
- ctrl_start and ctrl_stop in the same cycle: stop wins. ctrl_start outside IDLE is ignored. ctrl_stop in IDLE is ignored.
- Write is accepted iff level < DEPTH, evaluated before any same-cycle pop. A write while full is dropped and sets overflow.
- Write and pop in the same cycle: level unchanged, both take effect.
- Flush and write in the same cycle: flush wins and the write is lost; overflow is not set.
- A flag-setting event and clr_flags in the same cycle: the flag is set.
- pwm_en = 1 in RUN and STOPPING, else 0.

## Timing
- Reset values: duty = IDLE_DUTY, duty_load = 0, pwm_en = 0, level = 0, wr_full = 0, running = 0, underrun = 0, overflow = 0, irq = 0, state = IDLE, counter = 0, FIFO pointers = 0.
- All outputs are registered except wr_full, running and irq, which are decoded from registers.
- duty and duty_load update at the edge that ends the tick cycle.
- duty_load is high for exactly one cycle per pop.
- Level updates at the edge after the write/pop.
- PRIME→RUN: first tick occurs PERIOD cycles after the cycle in which RUN is entered.
- Tick spacing in RUN is exactly PERIOD cycles.
- reset_n asserted mid-operation: immediate return to reset values; FIFO contents discarded.

## Structure
- Shared package pwm_sched_pkg holds:
  - state encoding (IDLE=0, PRIME=1, RUN=2, STOPPING=3)
  - IDLE_DUTY default and the counter width (24)
- Sub-module sync_fifo_8 (DEPTH-parameterised, 8-bit). Ports: push, pop, flush, dout (combinational read of head), level.
- Scheduler FSM, tick counter and flags stay in pwm_sample_sched.

## Test plan
- Reset: hold reset_n low mid-RUN → all outputs at reset values; duty = 0x80, level = 0.
- Prime/play (PERIOD=10): write 8 samples 0x10..0x17, pulse start → RUN when level = 8. duty_load pulses every 10 cycles, first 10 cycles after RUN entry; duty sequence 0x10..0x17.
- Underrun: prime 8 samples, write none further → 9th tick sets underrun. duty stays 0x17, no duty_load. clr_flags then clears underrun.
- Overflow: write 17 samples in IDLE → level = 16, wr_full = 1, overflow = 1. Write plus tick pop on a full FIFO in the same cycle → write dropped, level = 15.
- Stop: ctrl_stop mid-period → pwm_en stays 1 until the next tick. Then duty = 0x80 with duty_load, level = 0, running = 0.
- Corner cases: start+stop in the same cycle in IDLE → stays IDLE. irq asserts once RUN and level ≤ 4; irq deasserts in IDLE.

Source files
------------

// File: rtl/pwm_sched_pkg.sv
// Shared definitions for the PWM sample scheduler: state encoding, counter width, defaults.
package pwm_sched_pkg;

  localparam int unsigned CNT_W = 24;

  localparam logic [7:0] IDLE_DUTY_DEF = 8'h80;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StPrime    = 2'd1;
  localparam logic [1:0] StRun      = 2'd2;
  localparam logic [1:0] StStopping = 2'd3;

  // Occupancy counter needs one extra bit so a full FIFO is distinguishable from empty.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pwm_sample_sched_if.sv
// Bus-side bundle of the PWM sample scheduler: sample writes, control pulses and status.
interface pwm_sample_sched_if #(
  parameter int unsigned DEPTH = 16
);
  import pwm_sched_pkg::*;

  localparam int unsigned LvlW = lvl_w(DEPTH);

  logic            wr_en;
  logic [7:0]      wr_data;
  logic            ctrl_start;
  logic            ctrl_stop;
  logic            clr_flags;
  logic [7:0]      duty;
  logic            duty_load;
  logic            pwm_en;
  logic [LvlW-1:0] level;
  logic            wr_full;
  logic            running;
  logic            underrun;
  logic            overflow;
  logic            irq;

  modport master (
    output wr_en, wr_data, ctrl_start, ctrl_stop, clr_flags,
    input  duty, duty_load, pwm_en, level, wr_full, running, underrun, overflow, irq
  );

  modport slave (
    input  wr_en, wr_data, ctrl_start, ctrl_stop, clr_flags,
    output duty, duty_load, pwm_en, level, wr_full, running, underrun, overflow, irq
  );

endinterface

// File: rtl/sync_fifo_8.sv
// 8-bit synchronous FIFO with head look-ahead, occupancy count and single-cycle flush.
module sync_fifo_8 #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  input  logic                   flush,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  // Caller guarantees no push when full and no pop when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/pwm_sample_sched.sv
// Sample-rate scheduler: buffers duty samples and hands one to the PWM stage per sample tick.
module pwm_sample_sched
  import pwm_sched_pkg::*;
#(
  parameter int unsigned PERIOD    = 12000,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PRIME_LVL = 8,
  parameter int unsigned LOW_WATER = 4,
  parameter logic [7:0]  IDLE_DUTY = IDLE_DUTY_DEF
) (
  input logic               clk,
  input logic               reset_n,
  pwm_sample_sched_if.slave bus
);

  localparam int unsigned       LvlW    = lvl_w(DEPTH);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(PERIOD - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       duty_q, duty_d;
  logic             load_q, load_d;
  logic             pwm_en_q, pwm_en_d;
  logic             underrun_q, underrun_d;
  logic             overflow_q, overflow_d;

  logic [LvlW-1:0]  level;
  logic [7:0]       head;
  logic             active, tick, fifo_empty, fifo_full;
  logic             push, pop, flush;

  assign active     = (state_q == StRun) || (state_q == StStopping);
  assign tick       = active && (cnt_q == LastCnt);
  assign fifo_full  = (32'(level) == DEPTH);
  assign fifo_empty = (level == '0);
  assign pop        = tick && (state_q == StRun) && !fifo_empty;
  assign flush      = tick && (state_q == StStopping);
  // Fullness is judged before any same-cycle pop; a flush swallows a concurrent write.
  assign push       = bus.wr_en && !fifo_full && !flush;

  sync_fifo_8 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (bus.wr_data),
    .pop     (pop),
    .flush   (flush),
    .dout    (head),
    .level   (level)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (bus.ctrl_start && !bus.ctrl_stop) state_d = StPrime;
      StPrime: begin
        if (bus.ctrl_stop)                   state_d = StIdle;
        else if (32'(level) >= PRIME_LVL)    state_d = StRun;
      end
      StRun:      if (bus.ctrl_stop) state_d = StStopping;
      StStopping: if (tick) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Counter only advances while staying in an active state, so RUN always begins at zero.
  always_comb begin
    cnt_d = '0;
    if (active && (state_d != StIdle)) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    duty_d     = duty_q;
    load_d     = 1'b0;
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    pwm_en_d   = (state_d == StRun) || (state_d == StStopping);
    if (pop) begin
      duty_d = head;
      load_d = 1'b1;
    end else if (flush) begin
      duty_d = IDLE_DUTY;
      load_d = 1'b1;
    end
    if (tick && (state_q == StRun) && fifo_empty) underrun_d = 1'b1;
    else if (bus.clr_flags)                       underrun_d = 1'b0;
    if (bus.wr_en && fifo_full && !flush) overflow_d = 1'b1;
    else if (bus.clr_flags)               overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      duty_q     <= IDLE_DUTY;
      load_q     <= 1'b0;
      pwm_en_q   <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      load_q     <= load_d;
      pwm_en_q   <= pwm_en_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.duty      = duty_q;
  assign bus.duty_load = load_q;
  assign bus.pwm_en    = pwm_en_q;
  assign bus.level     = level;
  assign bus.wr_full   = fifo_full;
  assign bus.running   = (state_q != StIdle);
  assign bus.underrun  = underrun_q;
  assign bus.overflow  = overflow_q;
  assign bus.irq       = (state_q != StIdle) && (32'(level) <= LOW_WATER);

endmodule

// File: tb/tb_pwm_sample_sched.sv
// Bench for pwm_sample_sched: vector table, directed sequences and random traffic vs a queue model.
module tb_pwm_sample_sched;

  localparam int unsigned PERIOD    = 10;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned PRIME_LVL = 8;
  localparam int unsigned LOW_WATER = 4;
  localparam logic [7:0]  IDLE_DUTY = 8'h80;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  pwm_sample_sched_if #(.DEPTH(DEPTH)) bus ();

  pwm_sample_sched #(
    .PERIOD    (PERIOD),
    .DEPTH     (DEPTH),
    .PRIME_LVL (PRIME_LVL),
    .LOW_WATER (LOW_WATER),
    .IDLE_DUTY (IDLE_DUTY)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {MIdle, MPrime, MRun, MStop} mode_e;

  mode_e      m_mode;
  logic [7:0] m_fifo[$];
  int         m_phase;
  logic [7:0] m_duty;
  logic       m_load, m_under, m_over;

  task automatic model_reset();
    m_mode  = MIdle;
    m_fifo.delete();
    m_phase = 0;
    m_duty  = IDLE_DUTY;
    m_load  = 1'b0;
    m_under = 1'b0;
    m_over  = 1'b0;
  endtask

  task automatic model_step();
    int    pre;
    logic  tick, accept, flush, set_under, set_over;
    mode_e nxt;
    pre       = m_fifo.size();
    tick      = (m_mode == MRun || m_mode == MStop) && (m_phase % PERIOD == PERIOD - 1);
    accept    = bus.wr_en && (pre < DEPTH);
    flush     = tick && (m_mode == MStop);
    set_under = tick && (m_mode == MRun) && (pre == 0);
    set_over  = bus.wr_en && !accept && !flush;
    m_load    = 1'b0;
    if (tick && m_mode == MRun && pre > 0) begin
      m_duty = m_fifo.pop_front();
      m_load = 1'b1;
    end
    if (flush) begin
      m_fifo.delete();
      m_duty = IDLE_DUTY;
      m_load = 1'b1;
    end else if (accept) begin
      m_fifo.push_back(bus.wr_data);
    end
    if (set_under) m_under = 1'b1;
    else if (bus.clr_flags) m_under = 1'b0;
    if (set_over) m_over = 1'b1;
    else if (bus.clr_flags) m_over = 1'b0;
    nxt = m_mode;
    case (m_mode)
      MIdle:  if (bus.ctrl_start && !bus.ctrl_stop) nxt = MPrime;
      MPrime: if (bus.ctrl_stop) nxt = MIdle; else if (pre >= PRIME_LVL) nxt = MRun;
      MRun:   if (bus.ctrl_stop) nxt = MStop;
      MStop:  if (flush) nxt = MIdle;
      default: nxt = MIdle;
    endcase
    if ((m_mode == MRun || m_mode == MStop) && (nxt == MRun || nxt == MStop)) m_phase++;
    else m_phase = 0;
    m_mode = nxt;
  endtask

  function automatic logic [19:0] model_out();
    int   n;
    logic act, run;
    n   = m_fifo.size();
    act = (m_mode == MRun) || (m_mode == MStop);
    run = (m_mode != MIdle);
    return {m_duty, m_load, act, 5'(n), (n == DEPTH), run, m_under, m_over,
            run && (n <= LOW_WATER)};
  endfunction

  function automatic logic [19:0] dut_out();
    return {bus.duty, bus.duty_load, bus.pwm_en, bus.level, bus.wr_full, bus.running,
            bus.underrun, bus.overflow, bus.irq};
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset_n) model_reset();
    check("model", dut_out(), model_out());
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.wr_en      = 1'b0;
    bus.wr_data    = 8'h00;
    bus.ctrl_start = 1'b0;
    bus.ctrl_stop  = 1'b0;
    bus.clr_flags  = 1'b0;
  endtask

  task automatic write(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse(input int which);
    if (which == 0) bus.ctrl_start = 1'b1;
    if (which == 1) bus.ctrl_stop = 1'b1;
    if (which == 2) bus.clr_flags = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    step();
    step();
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_load(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.duty_load && n < limit);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".duty"}, bus.duty, 8'h80);
    check({tag, ".duty_load"}, bus.duty_load, 0);
    check({tag, ".pwm_en"}, bus.pwm_en, 0);
    check({tag, ".level"}, bus.level, 0);
    check({tag, ".wr_full"}, bus.wr_full, 0);
    check({tag, ".running"}, bus.running, 0);
    check({tag, ".underrun"}, bus.underrun, 0);
    check({tag, ".overflow"}, bus.overflow, 0);
    check({tag, ".irq"}, bus.irq, 0);
  endtask

  typedef struct {
    logic       start, stop, wr;
    logic [7:0] data;
    logic       clr;
    logic       e_run;
    logic [4:0] e_lvl;
    logic       e_irq;
  } vec_t;

  vec_t vt[11];

  initial begin
    int n, seen, lost, rate;

    // start, stop, wr, data, clr | running, level, irq
    vt[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0};  // start+stop: stop wins
    vt[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0};  // stop in IDLE ignored
    vt[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 5'd1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 5'd2, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 5'd3, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd3, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd3, 1'b1};
    vt[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd3, 1'b0};

    idle_inputs();
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    check_reset_vals("por");

    for (int i = 0; i < 11; i++) begin
      bus.ctrl_start = vt[i].start;
      bus.ctrl_stop  = vt[i].stop;
      bus.wr_en      = vt[i].wr;
      bus.wr_data    = vt[i].data;
      bus.clr_flags  = vt[i].clr;
      step();
      idle_inputs();
      check($sformatf("vec%0d.running", i), bus.running, vt[i].e_run);
      check($sformatf("vec%0d.level", i), bus.level, vt[i].e_lvl);
      check($sformatf("vec%0d.irq", i), bus.irq, vt[i].e_irq);
      check($sformatf("vec%0d.pwm_en", i), bus.pwm_en, 0);
      check($sformatf("vec%0d.duty_load", i), bus.duty_load, 0);
    end

    // Prime and play eight samples.
    do_reset();
    for (int i = 0; i < 8; i++) write(8'(8'h10 + i));
    check("prime.level", bus.level, 8);
    pulse(0);
    check("prime.running", bus.running, 1);
    check("prime.pwm_en", bus.pwm_en, 0);
    n = 0;
    while (!bus.pwm_en && n < 5) begin
      step();
      n++;
    end
    check("prime.run_entry", n, 1);
    for (int i = 0; i < 8; i++) begin
      wait_load(30, n);
      check($sformatf("play%0d.spacing", i), n, PERIOD);
      check($sformatf("play%0d.duty", i), bus.duty, 8'(8'h10 + i));
      check($sformatf("play%0d.irq", i), bus.irq, (7 - i) <= int'(LOW_WATER));
    end

    // Empty FIFO at the next tick: underrun, duty holds.
    seen = 0;
    repeat (PERIOD) begin
      step();
      if (bus.duty_load) seen++;
    end
    check("under.no_load", seen, 0);
    check("under.flag", bus.underrun, 1);
    check("under.duty", bus.duty, 8'h17);
    pulse(2);
    check("under.clr", bus.underrun, 0);

    // Stop mid-period: stays enabled until the tick, then idle duty and flush.
    write(8'hA1);
    write(8'hA2);
    pulse(1);
    check("stop.running", bus.running, 1);
    check("stop.level", bus.level, 2);
    n = 0;
    lost = 0;
    do begin
      if (!bus.pwm_en) lost++;
      step();
      n++;
    end while (!bus.duty_load && n < 30);
    check("stop.pwm_held", lost, 0);
    check("stop.latency", n, 6);
    check("stop.duty", bus.duty, 8'h80);
    check("stop.level0", bus.level, 0);
    check("stop.running0", bus.running, 0);
    check("stop.pwm_en0", bus.pwm_en, 0);
    check("stop.irq0", bus.irq, 0);

    // Overflow, then write and pop in the same cycle on a full FIFO.
    for (int i = 0; i < 17; i++) write(8'(8'h40 + i));
    check("ovf.level", bus.level, 16);
    check("ovf.full", bus.wr_full, 1);
    check("ovf.flag", bus.overflow, 1);
    pulse(2);
    check("ovf.clr", bus.overflow, 0);
    bus.wr_en      = 1'b1;
    bus.wr_data    = 8'hEE;
    bus.ctrl_start = 1'b1;
    step();
    bus.ctrl_start = 1'b0;
    wait_load(40, n);
    bus.wr_en = 1'b0;
    check("fullpop.latency", n, PERIOD + 1);
    check("fullpop.level", bus.level, 15);
    check("fullpop.duty", bus.duty, 8'h40);
    check("fullpop.overflow", bus.overflow, 1);
    step();
    check("fullpop.level_after", bus.level, 15);
    pulse(1);
    n = 0;
    while (bus.running && n < 30) begin
      step();
      n++;
    end
    check("fullpop.stopped", bus.running, 0);

    // Asynchronous reset in the middle of RUN.
    for (int i = 0; i < 8; i++) write(8'(8'h60 + i));
    pulse(0);
    n = 0;
    while (!bus.pwm_en && n < 5) begin
      step();
      n++;
    end
    check("rst.in_run", bus.pwm_en, 1);
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1 check_reset_vals("rst.async");
    step();
    #1 reset_n = 1'b1;
    step();
    check_reset_vals("rst.after");

    // Random traffic checked cycle by cycle against the model.
    rate = 10;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) rate = int'($urandom_range(1, 60));
      bus.wr_en      = ($urandom_range(0, 99) < rate);
      bus.wr_data    = 8'($urandom);
      bus.ctrl_start = ($urandom_range(0, 99) < 4);
      bus.ctrl_stop  = ($urandom_range(0, 99) < 1);
      bus.clr_flags  = ($urandom_range(0, 99) < 3);
      step();
    end
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
